// File: rtl/cricket_pkg.sv
// Shared encodings for the two-innings match engine: outcome codes, match states
// and winner codes.
package cricket_pkg;

  localparam logic [2:0] OUT_DOT    = 3'd0;
  localparam logic [2:0] OUT_ONE    = 3'd1;
  localparam logic [2:0] OUT_TWO    = 3'd2;
  localparam logic [2:0] OUT_THREE  = 3'd3;
  localparam logic [2:0] OUT_FOUR   = 3'd4;
  localparam logic [2:0] OUT_SIX    = 3'd5;
  localparam logic [2:0] OUT_WICKET = 3'd6;
  localparam logic [2:0] OUT_WIDE   = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INN1  = 3'd1,
    ST_BREAK = 3'd2,
    ST_INN2  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_TEAM0 = 2'b01;
  localparam logic [1:0] WIN_TEAM1 = 2'b10;
  localparam logic [1:0] WIN_TIE   = 2'b11;

  // Runs credited to the batting side for one outcome code (a wide is one extra).
  function automatic logic [3:0] outcome_runs(input logic [2:0] code);
    case (code)
      OUT_SIX:    outcome_runs = 4'd6;
      OUT_WICKET: outcome_runs = 4'd0;
      OUT_WIDE:   outcome_runs = 4'd1;
      default:    outcome_runs = {1'b0, code};
    endcase
  endfunction

endpackage

// File: rtl/cricket_match_engine_if.sv
// Manual-mode delivery handshake between the ball source and the match engine.
interface cricket_match_engine_if;
  logic       ball_valid;
  logic [2:0] ball_outcome;
  logic       ball_ready;

  modport master (output ball_valid, output ball_outcome, input ball_ready);
  modport slave  (input ball_valid, input ball_outcome, output ball_ready);
endinterface

// File: rtl/cricket_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) advancing only when step is high.
module cricket_lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  output logic [15:0] value
);

  logic fb;
  assign fb = value[15] ^ value[13] ^ value[12] ^ value[10];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      value <= SEED;
    else if (step) value <= {value[14:0], fb};
  end

endmodule

// File: rtl/cricket_match_engine.sv
// Two-innings limited-overs scorer: auto (LFSR) or manual deliveries, run chase,
// tie detection and registered match result.
module cricket_match_engine
  import cricket_pkg::*;
#(
  parameter int          BALLS_PER_OVER = 6,
  parameter int          OVERS          = 20,
  parameter int          MAX_WICKETS    = 10,
  parameter int          RUN_W          = 9,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  localparam int         MAX_BALLS      = BALLS_PER_OVER * OVERS,
  localparam int         BALL_W         = $clog2(MAX_BALLS + 1),
  localparam int         OVER_W         = $clog2(OVERS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 play,
  input  logic                 mode,
  cricket_match_engine_if.slave ball,
  output logic [RUN_W-1:0]     runs,
  output logic [3:0]           wickets,
  output logic [BALL_W-1:0]    ball_count,
  output logic [OVER_W-1:0]    over_count,
  output logic [RUN_W:0]       target,
  output logic                 batting_team,
  output logic                 innings_over,
  output logic                 game_over,
  output logic [1:0]           winner
);

  localparam int BIO_W = $clog2(BALLS_PER_OVER + 1);

  state_t            state, nxt;
  logic              play_q, mode_q;
  logic [BIO_W-1:0]  ball_in_over;
  logic [1:0]        win_q;
  logic [15:0]       lfsr;
  logic              lfsr_unused;

  logic              in_play, start, accept, legal, over_end, chased, inn_end;
  logic [2:0]        code;
  logic [RUN_W:0]    sum;
  logic [RUN_W-1:0]  runs_nx;
  logic [3:0]        wickets_nx;
  logic [BALL_W-1:0] balls_nx;
  logic [OVER_W-1:0] overs_nx;

  assign in_play         = (state == ST_INN1) || (state == ST_INN2);
  assign start           = play & ~play_q;
  assign ball.ball_ready = in_play & mode_q;
  // Auto deliveries skip the start cycle so a fresh play press never scores.
  assign accept = in_play & (mode_q ? ball.ball_valid : (play & ~start));
  assign code   = mode_q ? ball.ball_outcome : lfsr[2:0];
  assign lfsr_unused = ^lfsr[15:3];

  cricket_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .step  (accept & ~mode_q),
    .value (lfsr)
  );

  // Post-delivery values; end-of-innings is judged on these, not the old ones.
  assign legal      = (code != OUT_WIDE);
  assign sum        = {1'b0, runs} + (RUN_W+1)'(outcome_runs(code));
  assign runs_nx    = sum[RUN_W] ? '1 : sum[RUN_W-1:0];
  assign wickets_nx = wickets + 4'(code == OUT_WICKET);
  assign balls_nx   = ball_count + BALL_W'(legal);
  assign over_end   = legal && (ball_in_over == BIO_W'(BALLS_PER_OVER - 1));
  assign overs_nx   = over_count + OVER_W'(over_end);
  assign chased     = (state == ST_INN2) && ({1'b0, runs_nx} >= target);
  assign inn_end    = (balls_nx == BALL_W'(MAX_BALLS)) ||
                      (wickets_nx == 4'(MAX_WICKETS)) || chased;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:  if (start) nxt = ST_INN1;
      ST_INN1:  if (accept && inn_end) nxt = ST_BREAK;
      ST_BREAK: if (start) nxt = ST_INN2;
      ST_INN2:  if (accept && inn_end) nxt = ST_DONE;
      ST_DONE:  if (start) nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      play_q       <= 1'b0;
      mode_q       <= 1'b0;
      runs         <= '0;
      wickets      <= '0;
      ball_count   <= '0;
      over_count   <= '0;
      ball_in_over <= '0;
      target       <= '0;
      batting_team <= 1'b0;
      win_q        <= WIN_NONE;
    end else begin
      play_q <= play;
      if (accept) begin
        runs         <= runs_nx;
        wickets      <= wickets_nx;
        ball_count   <= balls_nx;
        over_count   <= overs_nx;
        ball_in_over <= over_end ? '0 : ball_in_over + BIO_W'(legal);
        if (inn_end && state == ST_INN1) target <= {1'b0, runs_nx} + 1'b1;
        if (inn_end && state == ST_INN2) begin
          if ({1'b0, runs_nx} >= target)              win_q <= WIN_TEAM1;
          else if ({1'b0, runs_nx} == target - 1'b1)  win_q <= WIN_TIE;
          else                                        win_q <= WIN_TEAM0;
        end
      end else if (start) begin
        case (state)
          ST_IDLE, ST_BREAK, ST_DONE: begin
            runs         <= '0;
            wickets      <= '0;
            ball_count   <= '0;
            over_count   <= '0;
            ball_in_over <= '0;
          end
          default: ;
        endcase
        case (state)
          ST_IDLE:  mode_q <= mode;
          ST_BREAK: batting_team <= 1'b1;
          ST_DONE: begin
            mode_q       <= 1'b0;
            target       <= '0;
            batting_team <= 1'b0;
            win_q        <= WIN_NONE;
          end
          default: ;
        endcase
      end
    end
  end

  assign innings_over = (state == ST_BREAK) || (state == ST_DONE);
  assign game_over    = (state == ST_DONE);
  assign winner       = (state == ST_DONE) ? win_q : WIN_NONE;

endmodule

// File: doc/cricket_match_engine.md
Name: cricket_match_engine

Overview:
- Parametrised two-innings limited-overs scoring engine; next generation of the single-innings cricket_game scorer.
- Adds configurable overs, balls-per-over, wicket limit and score width.
- Adds extras (wides), run-chase early finish, tie detection, and a manual outcome mode (external ball_outcome with valid/ready handshake) alongside the LFSR auto mode.
- Sits under the game top level and drives the score display and match-result logic.

Parameters:
- BALLS_PER_OVER, 6, legal deliveries per over.
- OVERS, 20, overs per innings; MAX_BALLS = BALLS_PER_OVER*OVERS.
- MAX_WICKETS, 10, wickets that end an innings.
- RUN_W, 9, width of run counters; counters saturate at 2^RUN_W-1.
- LFSR_SEED, 16'hACE1, nonzero reset value of the auto-mode LFSR.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- play  in  1  start/advance control; rising edge = start event; level high = auto deliveries enabled.
- mode  in  1  0 = auto (LFSR outcomes), 1 = manual (ball_outcome); sampled on the IDLE->INN1 start event only.
- ball_valid  in  1  manual-mode delivery strobe.
- ball_outcome  in  3  manual outcome code: 0 dot, 1..4 runs, 5 six, 6 wicket, 7 wide.
- ball_ready  out  1  high in INN1/INN2 when mode = manual.
- runs  out  RUN_W  current-innings runs.
- wickets  out  4  current-innings wickets.
- ball_count  out  $clog2(MAX_BALLS+1)  legal balls bowled this innings.
- over_count  out  $clog2(OVERS+1)  completed overs.
- target  out  RUN_W+1  first-innings score + 1; 0 before the break.
- batting_team  out  1  0 in INN1, 1 in INN2.
- innings_over  out  1  high in BREAK and DONE.
- game_over  out  1  high in DONE.
- winner  out  2  00 none, 01 team 0, 10 team 1, 11 tie; valid only in DONE.

Behaviour:
- States: IDLE, INN1, BREAK, INN2, DONE.
- Reset (any time, including mid-innings): state = IDLE; all outputs and counters = 0; LFSR = LFSR_SEED; mode register = 0.
- start = play & ~play_q, where play_q is a registered copy of play.
- Transitions on start:
  - IDLE -> INN1: latch mode, clear counters.
  - BREAK -> INN2: clear runs, wickets, ball_count, over_count.
  - DONE -> IDLE.
- Delivery accepted:
  - Auto: every cycle in INN1/INN2 with play = 1 and not the start cycle.
  - Manual: ball_valid & ball_ready; play is ignored.
- Auto outcome: lfsr[2:0]. The 16-bit Fibonacci LFSR (taps 16,14,13,11) steps on every accepted auto delivery only.
- Delivery update (registered, visible the cycle after acceptance):
  - codes 0-4: runs += code; ball_count++.
  - code 5: runs += 6; ball_count++.
  - code 6: wickets++; ball_count++.
  - code 7: runs += 1; ball_count unchanged.
  - runs saturates at 2^RUN_W-1.
  - over_count++ when ball_count reaches a multiple of BALLS_PER_OVER.
- End of innings, evaluated on the updated values in the same cycle as the update:
  - ball_count == MAX_BALLS, or wickets == MAX_WICKETS, or (INN2 and runs >= target).
  - INN1 -> BREAK: target = runs + 1.
  - INN2 -> DONE.
  - Deliveries presented in BREAK/DONE are ignored; ball_ready = 0.
- Winner, registered on entry to DONE:
  - runs >= target -> 10.
  - runs == target-1 -> 11.
  - otherwise -> 01.
- Simultaneous wicket and chase completion on the same ball cannot occur (a wicket adds no runs).
- A final-ball wide that completes the chase ends the innings normally.

Decomposition:
- Package cricket_pkg: outcome code localparams (OUT_DOT..OUT_WIDE), state enum encoding, winner code constants.
- Sub-module cricket_lfsr16 (seed parameter, step enable, 16-bit output).
- Everything else lives in cricket_match_engine.

Test Plan:
- Reset mid-INN1 after 3 balls -> next cycle: state IDLE; runs, wickets, ball_count = 0; winner = 00.
- Manual, OVERS=1, BALLS_PER_OVER=6, MAX_WICKETS=2; INN1 outcomes 4,5,7,0,1,2,3 -> runs = 17, ball_count = 6, over_count = 1, BREAK, target = 18.
- INN2 same config; outcomes 6,6 -> wickets = 2 after 2 balls, DONE, winner = 01.
- INN2 chasing target 18; outcomes 5,5,5 -> runs = 18 after 3 balls, DONE, winner = 10, ball_count = 3.
- INN2 scoring exactly 17 in 6 balls -> DONE, winner = 11.
- RUN_W=4; outcomes 5,5,5 -> runs saturates at 15.
- Auto mode, play held high, default params -> ball_ready = 0; innings ends at 120 balls or 10 wickets; two runs with the same seed give identical scores.
